// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory port: FSM states, requester ids and
// big-endian byte-lane geometry (lane 0 carries bits 31:24).
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam int unsigned LANE_COUNT = 4;
    localparam int unsigned LANE_WIDTH = 8;

    function automatic int unsigned lane_lsb(input int unsigned lane);
        return (LANE_COUNT - 1 - lane) * LANE_WIDTH;
    endfunction

endpackage

// File: rtl/mem_lane_pack.sv
// Combinational 32-bit word <-> big-endian byte-lane conversion; one
// direction packs write data, the other unpacks read data.
module mem_lane_pack
    import mips_mem_pkg::*;
(
    input  logic [31:0]                             word_in,
    output logic [0:LANE_COUNT-1][LANE_WIDTH-1:0]   lanes_out,
    input  logic [0:LANE_COUNT-1][LANE_WIDTH-1:0]   lanes_in,
    output logic [31:0]                             word_out
);

    for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(g);
        assign lanes_out[g]                 = word_in[LSB +: LANE_WIDTH];
        assign word_out[LSB +: LANE_WIDTH]  = lanes_in[g];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single byte-lane memory
// port. Optional I anti-starvation counter: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_b,
    input  logic                                    halted,
    input  logic                                    i_req,
    input  logic [31:0]                             i_addr,
    output logic                                    i_ready,
    output logic                                    i_rvalid,
    output logic [31:0]                             i_rdata,
    input  logic                                    d_req,
    input  logic                                    d_we,
    input  logic [31:0]                             d_addr,
    input  logic [31:0]                             d_wdata,
    output logic                                    d_ready,
    output logic                                    d_rvalid,
    output logic [31:0]                             d_rdata,
    output logic [31:0]                             mem_addr,
    output logic                                    mem_write_en,
    output logic [0:LANE_COUNT-1][LANE_WIDTH-1:0]   mem_data_in,
    input  logic [0:LANE_COUNT-1][LANE_WIDTH-1:0]   mem_data_out,
    output logic                                    busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..7");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..7");
    end

    localparam logic [2:0] WAIT_LOAD = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    state_t                                 state, state_next;
    req_id_t                                owner;
    logic                                   store_q;
    logic [2:0]                             wait_cnt;
    logic                                   can_grant, grant_i, grant_d, force_i;
    logic [31:0]                            rd_word;
    logic [0:LANE_COUNT-1][LANE_WIDTH-1:0]  wr_lanes;
    logic                                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    mem_lane_pack u_lane_pack (
        .word_in   (d_wdata),
        .lanes_out (wr_lanes),
        .lanes_in  (mem_data_out),
        .word_out  (rd_word)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    // Once D has won STARVE_LIMIT times over a waiting I, the tie goes to I.
    assign force_i = (starve_cnt >= 3'(STARVE_LIMIT)) && i_req;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Readies are gated by reset so every output reads 0 while it is held.
    assign can_grant = (state == IDLE) && !halted && !rst_b;
    assign grant_d   = can_grant && d_req && !force_i;
    assign grant_i   = can_grant && i_req && !grant_d;

    always_comb begin
        state_next = state;
        i_ready    = grant_i;
        d_ready    = grant_d;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = (READ_LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                i_rvalid   = (owner == REQ_I);
                d_rvalid   = (owner == REQ_D);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state        <= IDLE;
            owner        <= REQ_I;
            store_q      <= 1'b0;
            wait_cnt     <= '0;
            mem_addr     <= '0;
            mem_write_en <= 1'b0;
            mem_data_in  <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            state        <= state_next;
            mem_write_en <= 1'b0;
            mem_data_in  <= '0;
            if (grant_i || grant_d) begin
                owner    <= grant_d ? REQ_D : REQ_I;
                store_q  <= grant_d && d_we;
                mem_addr <= grant_d ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
                if (grant_d && d_we) begin
                    mem_write_en <= 1'b1;
                    mem_data_in  <= wr_lanes;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            // Read data is captured on the last cycle before RESP.
            if (state != RESP && state_next == RESP) begin
                if (owner == REQ_I) begin
                    i_rdata <= rd_word;
                end else begin
                    d_rdata <= store_q ? '0 : rd_word;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single byte-lane data memory port between two requesters: instruction fetch (I) and load/store (D).
- Sits between the fetch/datapath logic and the memory model.
- Sequences each access through a small FSM (request, wait for memory latency, respond) and fixes the priority between requesters.
- Honours the core's halted signal by refusing new grants.

Parameters:
- READ_LATENCY, 1, cycles from memory address valid to read data valid; legal range 1..7.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset; asynchronous, active-high: asserted when 1, despite the name.
- halted  in  1  core halted; while 1, no new grants.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid, one-cycle pulse.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  data completion, one-cycle pulse; fires for loads and stores.
- d_rdata  out  32  load data; 0 for stores.
- mem_addr  out  32  memory word address.
- mem_write_en  out  1  memory write strobe.
- mem_data_in  out  8 x [0:3]  write bytes to memory.
- mem_data_out  in  8 x [0:3]  read bytes from memory.
- busy  out  1  access in flight, i.e. state != IDLE.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Any in-flight access is dropped with no rvalid. A reset in the middle of an access produces no rvalid after it is released.
- FSM states:
  - IDLE.
  - ISSUE: exactly 1 cycle.
  - WAIT: READ_LATENCY-1 cycles; skipped when READ_LATENCY = 1.
  - RESP: exactly 1 cycle, then back to IDLE.
- Acceptance:
  - x_ready is combinational and can be 1 only when state is IDLE and halted = 0.
  - An access is accepted in cycle A when x_req = 1 and x_ready = 1.
  - At most one of i_ready and d_ready is 1 in any cycle.
  - A requester holds req and its address/data stable until ready.
- Priority: D beats I when both request in the same cycle.
- Cycle A+1 (ISSUE):
  - mem_addr = {addr[31:2], 2'b00}; the low address bits are ignored.
  - mem_write_en = 1 for a store, 0 otherwise. It is high for exactly one cycle per store.
  - mem_data_in = d_wdata bytes, big-endian: lane 0 = bits 31:24, lane 3 = bits 7:0.
- Address and write data are registered at acceptance; they are not taken from the live inputs.
- mem_addr holds its value from ISSUE until the next ISSUE. mem_data_in is 0 outside a store's ISSUE cycle.
- Loads and fetches sample mem_data_out at cycle A+READ_LATENCY. The data is assembled big-endian and presented on x_rdata together with a pulse on x_rvalid in cycle A+1+READ_LATENCY (the RESP state).
- Stores pass through the same WAIT/RESP timing. d_rvalid pulses in RESP with d_rdata = 0.
- x_rdata holds its last value after RESP. Only the matching requester's rvalid pulses.
- Throughput: one access per READ_LATENCY+2 cycles. The earliest next acceptance is the cycle after RESP.
- halted:
  - Sampled only for granting.
  - halted rising during ISSUE/WAIT/RESP does not abort the access; it completes normally.
  - While halted = 1, busy falls to 0 after RESP and stays 0.
- With the optional feature absent, I can starve indefinitely under continuous d_req. This is acceptable in the single-cycle core.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit counter increments on each D grant made while i_req = 1.
  - When it reaches STARVE_LIMIT, the next arbitration with both requesting grants I, and the counter clears.
  - The counter also clears on any I grant and on reset.
- When undefined: strict D priority, and no counter logic is present.

Decomposition:
- Shared package mips_mem_pkg holds:
  - The FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - A requester-id enum (REQ_I, REQ_D).
  - The byte-lane pack/unpack constants for big-endian lane order.
- One natural sub-module, mem_lane_pack, does the combinational 32-bit <-> [0:3] byte-lane conversion. It is used for both write packing and read unpacking.

Test Plan:
- Single fetch, READ_LATENCY = 1:
  - Stimulus: i_req with i_addr = 0x00000106, memory returns lanes {0x12,0x34,0x56,0x78}.
  - Required: mem_addr = 0x00000104 at A+1, i_rvalid at A+2, i_rdata = 0x12345678.
- Store:
  - Stimulus: d_we = 1, d_addr = 0x20, d_wdata = 0xDEADBEEF.
  - Required: mem_write_en high for one cycle only, lanes {DE,AD,BE,EF}, d_rvalid one cycle later, d_rdata = 0.
- Simultaneous requests (i_req and d_req both 1):
  - Required: d_ready first. i_ready is next asserted the cycle after the D RESP; no overlapping rvalids.
  - With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4 and continuous d_req: I is granted on the 5th arbitration.
- READ_LATENCY = 3, load:
  - Required: d_rvalid exactly 4 cycles after acceptance; busy high for 4 cycles.
  - A fresh d_req held throughout is not accepted until after RESP.
- halted = 1 raised during WAIT: the access completes with rvalid, then i_ready and d_ready stay 0 while requests are held.
- rst_b pulsed during WAIT: all outputs are 0 immediately (asynchronously), and no rvalid appears after release.
